// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle MIPS control FSM with memory req/rdy handshake,
// wait timeout and illegal-op trap. Define MC_CTRL_MULDIV_EN for mul/div.
module mc_ctrl_hs #(
  parameter int ALUOP_W = 4,
  parameter int TMO_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Zero,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_rdy,
  input  logic               md_done,
  output logic               mem_req,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               IorD,
  output logic               EXTOp,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_MDW  = 3'd5;
  localparam logic [2:0] S_TRAP = 3'd6;

  localparam logic [1:0] C_ILL  = 2'd1;
  localparam logic [1:0] C_IFT  = 2'd2;
  localparam logic [1:0] C_MEMT = 2'd3;

  localparam logic [3:0] A_ADD = 4'd1;
  localparam logic [3:0] A_SUB = 4'd2;

  // one stalled cycle short of all-ones: the step that reaches the limit
  localparam logic [TMO_W-1:0] TMO_LIM = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] ONE     = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic [3:0]       alu_code;
  logic             stall, tmo;

  logic rtype;
  logic i_add, i_sub, i_and, i_or, i_nor, i_slt, i_sltu;
  logic i_sll, i_srl, i_sllv, i_srlv, i_jr, i_jalr;
  logic i_addi, i_andi, i_ori, i_slti, i_lui;
  logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic i_md, i_mfhi, i_mflo;
  logic r_alu, imm_alu, legal;

  assign rtype  = (Op == 6'h00);
  assign i_add  = rtype & (Funct[5:1] == 5'b10000);
  assign i_sub  = rtype & (Funct[5:1] == 5'b10001);
  assign i_and  = rtype & (Funct == 6'h24);
  assign i_or   = rtype & (Funct == 6'h25);
  assign i_nor  = rtype & (Funct == 6'h27);
  assign i_slt  = rtype & (Funct == 6'h2a);
  assign i_sltu = rtype & (Funct == 6'h2b);
  assign i_sll  = rtype & (Funct == 6'h00);
  assign i_srl  = rtype & (Funct == 6'h02);
  assign i_sllv = rtype & (Funct == 6'h04);
  assign i_srlv = rtype & (Funct == 6'h06);
  assign i_jr   = rtype & (Funct == 6'h08);
  assign i_jalr = rtype & (Funct == 6'h09);
  assign i_addi = (Op == 6'h08);
  assign i_slti = (Op == 6'h0a);
  assign i_andi = (Op == 6'h0c);
  assign i_ori  = (Op == 6'h0d);
  assign i_lui  = (Op == 6'h0f);
  assign i_lw   = (Op == 6'h23);
  assign i_sw   = (Op == 6'h2b);
  assign i_beq  = (Op == 6'h04);
  assign i_bne  = (Op == 6'h05);
  assign i_j    = (Op == 6'h02);
  assign i_jal  = (Op == 6'h03);

`ifdef MC_CTRL_MULDIV_EN
  assign i_md   = rtype & (Funct[5:2] == 4'b0110);
  assign i_mfhi = rtype & (Funct == 6'h10);
  assign i_mflo = rtype & (Funct == 6'h12);
`else
  logic unused_md;
  assign unused_md = md_done;
  assign i_md   = 1'b0;
  assign i_mfhi = 1'b0;
  assign i_mflo = 1'b0;
`endif

  assign r_alu = i_add | i_sub | i_and | i_or | i_nor | i_slt | i_sltu
               | i_sll | i_srl | i_sllv | i_srlv;
  assign imm_alu = i_addi | i_andi | i_ori | i_slti | i_lui;
  assign legal = r_alu | imm_alu | i_jr | i_jalr | i_lw | i_sw
               | i_beq | i_bne | i_j | i_jal | i_md | i_mfhi | i_mflo;

  assign stall = ((state_q == S_IF) | (state_q == S_MEM)) & ~mem_rdy;
  assign tmo   = stall & (cnt_q == TMO_LIM);

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = trap ? cause_q : 2'd0;
  assign state_o    = {1'b0, state_q};

  // ALU operation code for the instruction held in IR
  always_comb begin
    alu_code = A_ADD;
    unique case (1'b1)
      i_sub:          alu_code = A_SUB;
      i_and | i_andi: alu_code = 4'd3;
      i_or  | i_ori:  alu_code = 4'd4;
      i_slt | i_slti: alu_code = 4'd5;
      i_sltu:         alu_code = 4'd6;
      i_sll:          alu_code = 4'd7;
      i_nor:          alu_code = 4'd8;
      i_lui:          alu_code = 4'd9;
      i_srl:          alu_code = 4'd13;
      i_sllv:         alu_code = 4'd14;
      i_srlv:         alu_code = 4'd15;
      default:        alu_code = A_ADD;
    endcase
  end

  // next state and per-state datapath controls
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    mem_req  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    EXTOp    = 1'b1;
    ALUSrcA  = 2'd1;
    ALUSrcB  = 2'd0;
    ALUOp    = ALUOP_W'(A_ADD);
    PCSource = 2'd0;
    GPRSel   = 2'd0;
    WDSel    = 2'd0;
    md_start = 1'b0;
    md_op    = 2'd0;
    case (state_q)
      S_IF: begin
        mem_req = 1'b1;
        ALUSrcA = 2'd0;
        ALUSrcB = 2'd1;
        if (mem_rdy) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          state_d = S_ID;
        end else if (tmo) begin
          state_d = S_TRAP;
          cause_d = C_IFT;
        end
      end
      S_ID: begin
        if (i_j | i_jal | i_jr | i_jalr) begin
          PCWrite  = 1'b1;
          PCSource = (i_jr | i_jalr) ? 2'd3 : 2'd2;
          if (i_jal | i_jalr) begin
            RegWrite = 1'b1;
            WDSel    = 2'd2;
            GPRSel   = 2'd2;
          end
          state_d = S_IF;
        end else if (!legal) begin
          state_d = S_TRAP;
          cause_d = C_ILL;
        end else if (i_sll | i_srl) begin
          ALUSrcA = 2'd2;
          state_d = S_EXE;
        end else begin
          ALUSrcA = 2'd0;
          ALUSrcB = 2'd3;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        ALUOp = ALUOP_W'(alu_code);
        if (i_sll | i_srl) ALUSrcA = 2'd2;
        if (i_beq | i_bne) begin
          ALUOp    = ALUOP_W'(A_SUB);
          PCSource = 2'd1;
          PCWrite  = i_beq ? Zero : ~Zero;
          state_d  = S_IF;
        end else if (i_lw | i_sw) begin
          ALUSrcB = 2'd2;
          state_d = S_MEM;
        end else if (imm_alu) begin
          ALUSrcB = 2'd2;
          EXTOp   = ~(i_andi | i_ori);
          state_d = S_WB;
        end else if (i_md) begin
`ifdef MC_CTRL_MULDIV_EN
          md_start = 1'b1;
          md_op    = Funct[1:0];
          state_d  = S_MDW;
`endif
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = i_sw;
        if (mem_rdy) begin
          state_d = i_sw ? S_IF : S_WB;
        end else if (tmo) begin
          state_d = S_TRAP;
          cause_d = C_MEMT;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        if (i_lw) WDSel = 2'd1;
        if (i_mfhi | i_mflo) begin
          WDSel = 2'd3;
`ifdef MC_CTRL_MULDIV_EN
          md_op = {1'b0, i_mfhi};
`endif
        end
        GPRSel  = (i_lw | imm_alu) ? 2'd1 : 2'd0;
        state_d = S_IF;
      end
`ifdef MC_CTRL_MULDIV_EN
      S_MDW: begin
        if (md_done) state_d = S_IF;
      end
`endif
      S_TRAP: state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // wait counter: counts stalled cycles in place, saturating
  always_comb begin
    cnt_d = '0;
    if (stall && (state_d == state_q))
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + ONE;
  end

  // state, wait counter and trap cause registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// tb_mc_ctrl_hs: directed bench for mc_ctrl_hs (TMO_W=3).
// Expected values are hand-derived per cycle.
module tb_mc_ctrl_hs;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Zero = 1'b0;
  logic [5:0] Op = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       mem_rdy = 1'b0;
  logic       md_done = 1'b0;
  logic       mem_req, RegWrite, MemWrite, PCWrite, IRWrite, IorD, EXTOp;
  logic [1:0] ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel;
  logic [3:0] ALUOp;
  logic       md_start, trap;
  logic [1:0] md_op, trap_cause;
  logic [3:0] state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int irw = 0;
  logic [0:9] lw_rdy = 10'b0011100011;

  mc_ctrl_hs #(.ALUOP_W(4), .TMO_W(3)) dut (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
    .mem_rdy(mem_rdy), .md_done(md_done), .mem_req(mem_req),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .IorD(IorD), .EXTOp(EXTOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .GPRSel(GPRSel), .WDSel(WDSel),
    .md_start(md_start), .md_op(md_op), .trap(trap),
    .trap_cause(trap_cause), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic rdy);
    mem_rdy = rdy;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_state", state_o, 0);
    check("rst_mem_req", mem_req, 1);
    check("rst_srcb", ALUSrcB, 1);
    check("rst_trap", trap, 0);
    check("rst_cause", trap_cause, 0);

    // add, zero wait: IF ID EXE WB IF
    Op = 6'h00; Funct = 6'h20; go(1);
    check("add_if_irw", IRWrite, 1);
    check("add_if_pcw", PCWrite, 1);
    tick; check("add_id", state_o, 1);
    tick; check("add_exe", state_o, 2);
    check("add_aluop", ALUOp, 1);
    tick; check("add_wb", state_o, 4);
    check("add_rw", RegWrite, 1);
    check("add_gpr", GPRSel, 0);
    tick; check("add_done", state_o, 0);

    // sw interrupted by reset while stalled in MEM
    Op = 6'h2b; go(1);
    tick; check("sw_id", state_o, 1);
    tick; check("sw_exe", state_o, 2);
    check("sw_exe_srcb", ALUSrcB, 2);
    tick; go(0);
    for (int i = 0; i < 3; i++) begin
      check("sw_mem_st", state_o, 3);
      check("sw_mem_mw", MemWrite, 1);
      tick;
    end
    rst = 1'b1; #1;
    check("sw_rst_mw", MemWrite, 0);
    check("sw_rst_st", state_o, 0);
    tick; rst = 1'b0; #1;
    check("post_rst_st", state_o, 0);
    check("post_rst_mw", MemWrite, 0);
    check("post_rst_req", mem_req, 1);

    // sw data timeout: 7 stalled MEM cycles -> TRAP cause 3
    go(1);
    tick; tick; tick; go(0);
    for (int i = 0; i < 7; i++) begin
      check("dto_mem_st", state_o, 3);
      check("dto_trap0", trap, 0);
      tick;
    end
    check("dto_trap_st", state_o, 6);
    check("dto_trap", trap, 1);
    check("dto_cause", trap_cause, 3);
    check("dto_mw", MemWrite, 0);
    tick; check("dto_back", state_o, 0);

    // lw with 2 fetch waits and 3 data waits: 10 cycles
    Op = 6'h23; irw = 0;
    for (int c = 0; c < 10; c++) begin
      go(lw_rdy[c]);
      irw += int'(IRWrite);
      if (c == 2) check("lw_irw", IRWrite, 1);
      if (c == 9) begin
        check("lw_wb", state_o, 4);
        check("lw_wdsel", WDSel, 1);
        check("lw_gpr", GPRSel, 1);
        check("lw_rw", RegWrite, 1);
      end
      tick;
    end
    check("lw_len", state_o, 0);
    check("lw_irw_cnt", irw, 1);

    // fetch timeout: 7 stalled IF cycles -> TRAP cause 2
    Op = 6'h00; Funct = 6'h20; go(0);
    for (int i = 0; i < 7; i++) begin
      check("fto_if_st", state_o, 0);
      check("fto_trap0", trap, 0);
      tick;
    end
    check("fto_trap_st", state_o, 6);
    check("fto_trap", trap, 1);
    check("fto_cause", trap_cause, 2);
    tick;
    check("fto_back", state_o, 0);
    check("fto_pcw", PCWrite, 0);
    check("fto_cause0", trap_cause, 0);

    // ready on the 7th stalled cycle wins over the timeout
    for (int i = 0; i < 5; i++) begin
      tick;
      check("rdy_if_st", state_o, 0);
    end
    tick;
    Op = 6'h02; go(1);
    check("rdy7_trap", trap, 0);
    check("rdy7_pcw", PCWrite, 1);
    tick; check("j_id", state_o, 1);
    check("j_pcw", PCWrite, 1);
    check("j_pcsrc", PCSource, 2);
    tick; check("j_done", state_o, 0);

    // jal links r31 with PC
    Op = 6'h03; go(1);
    tick;
    check("jal_rw", RegWrite, 1);
    check("jal_wdsel", WDSel, 2);
    check("jal_gpr", GPRSel, 2);
    tick; check("jal_done", state_o, 0);

    // beq and bne with Zero=0
    Zero = 1'b0; Op = 6'h04; go(1);
    tick; tick;
    check("beq_exe", state_o, 2);
    check("beq_aluop", ALUOp, 2);
    check("beq_pcw", PCWrite, 0);
    tick; check("beq_done", state_o, 0);
    Op = 6'h05; go(1);
    tick; tick;
    check("bne_pcw", PCWrite, 1);
    check("bne_pcsrc", PCSource, 1);
    tick; check("bne_done", state_o, 0);

    // ori: zero-extend, OR, rt destination
    Op = 6'h0d; go(1);
    tick; tick;
    check("ori_ext", EXTOp, 0);
    check("ori_aluop", ALUOp, 4);
    check("ori_srcb", ALUSrcB, 2);
    tick;
    check("ori_wb", state_o, 4);
    check("ori_gpr", GPRSel, 1);
    tick; check("ori_done", state_o, 0);

    // div
    Op = 6'h00; Funct = 6'h1a; go(1);
    tick;
`ifdef MC_CTRL_MULDIV_EN
    tick; md_done = 1'b1; #1;
    check("div_exe", state_o, 2);
    check("div_start", md_start, 1);
    check("div_op", md_op, 2);
    tick; md_done = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      check("div_mdw", state_o, 5);
      check("div_start0", md_start, 0);
      tick;
    end
    md_done = 1'b1; #1;
    check("div_mdw_last", state_o, 5);
    tick; md_done = 1'b0; #1;
    check("div_done", state_o, 0);
`else
    check("div_id", state_o, 1);
    tick;
    check("div_trap_st", state_o, 6);
    check("div_trap", trap, 1);
    check("div_cause", trap_cause, 1);
    check("div_start0", md_start, 0);
    tick; check("div_back", state_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
